// File: rtl/id_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_operand_stage_if
//  Brief    : Bus bundle between the ID operand stage and its neighbours:
//             IF/ID handshake, decoder source fields, forwarding buses,
//             regfile write port, resolved operands and interlock status.
//  Revision : 1.0 - initial release
// ============================================================================
interface id_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NFWD    = 3,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) ();
  localparam int AW = $clog2(NREG);

  // Pipeline control and IF/ID
  logic [STALL_W-1:0]   stall;
  logic                 flush;
  logic                 if_valid;
  logic [31:0]          if_pc;
  logic                 id_valid;
  logic [31:0]          id_pc;

  // Decoder source fields
  logic [AW-1:0]        rs_addr;
  logic [AW-1:0]        rt_addr;
  logic                 rs_used;
  logic                 rt_used;

  // Forwarding buses, index 0 = youngest producer
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*AW-1:0]   fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic [NFWD-1:0]      fwd_pend;

  // Regfile write port
  logic                 wb_we;
  logic [AW-1:0]        wb_waddr;
  logic [XLEN-1:0]      wb_wdata;

  // Results
  logic [XLEN-1:0]      rdata1;
  logic [XLEN-1:0]      rdata2;
  logic                 stallreq;
  logic [CNT_W-1:0]     stall_cnt;

  // Operand stage view
  modport slave (
    input  stall, flush, if_valid, if_pc,
    input  rs_addr, rt_addr, rs_used, rt_used,
    input  fwd_we, fwd_waddr, fwd_wdata, fwd_pend,
    input  wb_we, wb_waddr, wb_wdata,
    output id_valid, id_pc, rdata1, rdata2, stallreq, stall_cnt
  );

  // Surrounding pipeline view
  modport master (
    output stall, flush, if_valid, if_pc,
    output rs_addr, rt_addr, rs_used, rt_used,
    output fwd_we, fwd_waddr, fwd_wdata, fwd_pend,
    output wb_we, wb_waddr, wb_wdata,
    input  id_valid, id_pc, rdata1, rdata2, stallreq, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_operand_stage
//  Brief    : ID-stage operand unit. IF/ID pipeline register, NREG x XLEN
//             register file, priority forwarding (youngest producer wins,
//             r0 never forwarded), load-use interlock and a saturating
//             interlock-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module id_operand_stage #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NFWD    = 3,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  id_operand_stage_if.slave     bus
);
  localparam int              AW        = $clog2(NREG);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic              r_id_valid;
  logic [31:0]       r_id_pc;
  logic [XLEN-1:0]   r_gpr [NREG];
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [AW-1:0]     w_src_addr [2];
  logic [XLEN-1:0]   w_opnd     [2];
  logic [1:0]        w_pend;
  logic              w_stallreq;
  logic              w_unused_stall;

  // Only bits 1 (IF/ID) and 2 (ID/EX) of the stall vector matter here.
  assign w_unused_stall = ^{bus.stall[0], bus.stall[STALL_W-1:3]};

  // IF/ID register: flush beats bubble insertion, which beats capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
    end else if (bus.flush) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
    end else if (bus.stall[1] && !bus.stall[2]) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
    end else if (!bus.stall[1]) begin
      r_id_valid <= bus.if_valid;
      r_id_pc    <= bus.if_pc;
    end
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_waddr != '0)) begin
      r_gpr[bus.wb_waddr] <= bus.wb_wdata;
    end
  end

  assign w_src_addr[0] = bus.rs_addr;
  assign w_src_addr[1] = bus.rt_addr;

  // One resolver per source port. The first matching forwarding source is
  // taken on its own so an older result can never leak into a younger one.
  // During reset the operands are forced to 0 so they read clean even while
  // the forwarding buses still carry stale traffic.
  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      logic            w_hit;
      logic [XLEN-1:0] w_val;
      logic            w_pnd;

      // Priority select: r0, youngest forward, WB bypass, then GPR.
      always_comb begin
        w_hit = 1'b0;
        w_pnd = 1'b0;
        w_val = r_gpr[w_src_addr[p]];
        if (rst || (w_src_addr[p] == '0)) begin
          w_val = '0;
        end else begin
          for (int i = 0; i < NFWD; i++) begin
            if (!w_hit && bus.fwd_we[i] &&
                (bus.fwd_waddr[i*AW +: AW] == w_src_addr[p])) begin
              w_hit = 1'b1;
              w_val = bus.fwd_wdata[i*XLEN +: XLEN];
              w_pnd = bus.fwd_pend[i];
            end
          end
          if (!w_hit && bus.wb_we && (bus.wb_waddr == w_src_addr[p])) begin
            w_val = bus.wb_wdata;
          end
        end
      end

      assign w_opnd[p] = w_val;
      assign w_pend[p] = w_pnd;
    end
  endgenerate

  // Interlock only when a used source selected a still-pending producer.
  assign w_stallreq = r_id_valid &
                      ((bus.rs_used & w_pend[0]) | (bus.rt_used & w_pend[1]));

  // Interlock-cycle counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stallreq && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.id_valid  = r_id_valid;
  assign bus.id_pc     = r_id_pc;
  assign bus.rdata1    = w_opnd[0];
  assign bus.rdata2    = w_opnd[1];
  assign bus.stallreq  = w_stallreq;
  assign bus.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_operand_stage
//  Brief    : Directed bench for id_operand_stage. Stimulus pushes expected
//             values into a queue; a monitor pops and compares them on the
//             falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;
  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int NFWD    = 3;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 8;
  localparam int AW      = 5;

  localparam int S_IDV = 0;
  localparam int S_PC  = 1;
  localparam int S_RD1 = 2;
  localparam int S_RD2 = 3;
  localparam int S_SRQ = 4;
  localparam int S_CNT = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  logic clk;
  logic rst;
  chk_t sb_q[$];
  int   n_checks;
  int   n_fail;

  id_operand_stage_if #(
    .XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .STALL_W(STALL_W), .CNT_W(CNT_W)
  ) bus ();

  id_operand_stage #(
    .XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .STALL_W(STALL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] actual(int sel);
    case (sel)
      S_IDV:   return 64'(bus.id_valid);
      S_PC:    return 64'(bus.id_pc);
      S_RD1:   return 64'(bus.rdata1);
      S_RD2:   return 64'(bus.rdata2);
      S_SRQ:   return 64'(bus.stallreq);
      default: return 64'(bus.stall_cnt);
    endcase
  endfunction

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        chk_t c;
        logic [63:0] a;
        c = sb_q.pop_front();
        a = actual(c.sel);
        n_checks++;
        if (a !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, a, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [63:0] v);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = v;
    sb_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d, input logic pend);
    bus.fwd_we[i]              = we;
    bus.fwd_waddr[i*AW +: AW]  = a;
    bus.fwd_wdata[i*XLEN +: XLEN] = d;
    bus.fwd_pend[i]            = pend;
  endtask

  initial begin
    rst           = 1'b1;
    bus.stall     = '0;
    bus.flush     = 1'b0;
    bus.if_valid  = 1'b0;
    bus.if_pc     = '0;
    bus.rs_addr   = '0;
    bus.rt_addr   = '0;
    bus.rs_used   = 1'b0;
    bus.rt_used   = 1'b0;
    bus.fwd_we    = '0;
    bus.fwd_waddr = '0;
    bus.fwd_wdata = '0;
    bus.fwd_pend  = '0;
    bus.wb_we     = 1'b0;
    bus.wb_waddr  = '0;
    bus.wb_wdata  = '0;
    step();
    step();

    // Reset state
    expect_val("rst_idv", S_IDV, 0);
    expect_val("rst_pc",  S_PC,  0);
    expect_val("rst_cnt", S_CNT, 0);
    expect_val("rst_rd1", S_RD1, 0);
    expect_val("rst_srq", S_SRQ, 0);
    step();
    rst = 1'b0;

    // Regfile write-through bypass and stored value
    bus.wb_we = 1'b1; bus.wb_waddr = 3; bus.wb_wdata = 32'h1234; bus.rs_addr = 3;
    expect_val("wb_bypass", S_RD1, 64'h1234);
    step();
    bus.wb_we = 1'b0;
    expect_val("gpr_read", S_RD1, 64'h1234);
    step();
    // r0 ignores writes and forwards
    bus.wb_we = 1'b1; bus.wb_waddr = 0; bus.wb_wdata = 32'hDEAD; bus.rs_addr = 0;
    expect_val("r0_wb_bypass", S_RD1, 0);
    step();
    bus.wb_we = 1'b0; bus.rt_addr = 0;
    set_fwd(0, 1'b1, 0, 32'hFFFF, 1'b0);
    expect_val("r0_fwd", S_RD1, 0);
    expect_val("r0_after_wb", S_RD2, 0);
    step();

    // Priority forwarding, youngest wins
    set_fwd(0, 1'b1, 5, 32'hA, 1'b0);
    set_fwd(1, 1'b1, 5, 32'hB, 1'b0);
    set_fwd(2, 1'b1, 5, 32'hC, 1'b0);
    bus.rs_addr = 5; bus.rt_addr = 5;
    expect_val("fwd_ex_rs", S_RD1, 64'hA);
    expect_val("fwd_ex_rt", S_RD2, 64'hA);
    step();
    bus.fwd_we[0] = 1'b0;
    expect_val("fwd_mem", S_RD1, 64'hB);
    step();
    bus.fwd_we[1] = 1'b0;
    bus.wb_we = 1'b1; bus.wb_waddr = 5; bus.wb_wdata = 32'hD;
    expect_val("fwd_wb_over_bypass", S_RD1, 64'hC);
    step();
    bus.fwd_we[2] = 1'b0;
    expect_val("bypass_only", S_RD1, 64'hD);
    step();
    bus.wb_we = 1'b0;
    bus.fwd_we = '0;

    // IF/ID register: capture, bubble, hold, flush
    bus.if_valid = 1'b1; bus.if_pc = 32'h100;
    step();
    expect_val("cap_idv", S_IDV, 1);
    expect_val("cap_pc",  S_PC,  64'h100);
    bus.stall = 6'b000010; bus.if_pc = 32'h104;
    step();
    expect_val("bubble_idv", S_IDV, 0);
    expect_val("bubble_pc",  S_PC,  0);
    bus.stall = 6'b000000; bus.if_pc = 32'h108;
    step();
    expect_val("cap2_pc", S_PC, 64'h108);
    bus.stall = 6'b000110; bus.if_pc = 32'h10C;
    step();
    expect_val("hold_pc",  S_PC,  64'h108);
    expect_val("hold_idv", S_IDV, 1);
    bus.flush = 1'b1;
    step();
    expect_val("flush_over_stall", S_IDV, 0);
    bus.flush = 1'b0; bus.stall = 6'b000000; bus.if_pc = 32'h110;
    step();
    expect_val("recap_idv", S_IDV, 1);
    bus.flush = 1'b1;
    step();
    expect_val("flush_idv", S_IDV, 0);
    bus.flush = 1'b0;

    // Load-use interlock
    bus.if_pc = 32'h200;
    step();
    bus.stall = 6'b000110;
    set_fwd(0, 1'b1, 8, 32'h88, 1'b1);
    bus.rt_addr = 8; bus.rt_used = 1'b1;
    expect_val("lu_srq", S_SRQ, 1);
    expect_val("lu_cnt0", S_CNT, 0);
    step();
    expect_val("lu_cnt1", S_CNT, 1);
    bus.rt_used = 1'b0;
    expect_val("unused_srq", S_SRQ, 0);
    step();
    bus.rt_used = 1'b1;
    set_fwd(0, 1'b1, 8, 32'h88, 1'b0);
    set_fwd(1, 1'b1, 8, 32'h99, 1'b1);
    expect_val("masked_srq", S_SRQ, 0);
    expect_val("masked_rd2", S_RD2, 64'h88);
    expect_val("masked_cnt", S_CNT, 1);
    step();
    bus.fwd_we[0] = 1'b0;
    expect_val("older_pend_srq", S_SRQ, 1);
    step();
    expect_val("older_pend_cnt", S_CNT, 2);

    // Saturation
    repeat ((1 << CNT_W) + 5) step();
    expect_val("sat_cnt", S_CNT, (64'd1 << CNT_W) - 1);
    expect_val("sat_srq", S_SRQ, 1);
    step();

    // Reset mid-stall takes effect before the next clock edge
    rst = 1'b1;
    set_fwd(0, 1'b1, 5, 32'h55, 1'b0);
    bus.rs_addr = 5;
    expect_val("mrst_idv", S_IDV, 0);
    expect_val("mrst_cnt", S_CNT, 0);
    expect_val("mrst_srq", S_SRQ, 0);
    expect_val("mrst_rd1", S_RD1, 0);
    step();
    rst = 1'b0;
    step();
    expect_val("post_rst_cnt", S_CNT, 0);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
